// File: rtl/pwm_avm_pkg.sv
// Shared types for the PWM Avalon-MM host: register map, FSM states, command bundle.
package pwm_avm_pkg;

    localparam logic [1:0] REG_CLK_DIV = 2'd0;
    localparam logic [1:0] REG_DUTY    = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RDWAIT,
        ST_RSP
    } state_e;

    typedef struct packed {
        logic        write;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } cmd_t;

endpackage

// File: rtl/pwm_avm_cmd_fifo.sv
// Command FIFO for the PWM Avalon-MM host; full flag is registered.
module pwm_avm_cmd_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [PW:0]      cnt_q;
    logic [PW:0]      cnt_d;
    logic             full_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && (cnt_q != '0);
    assign cnt_d   = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == (PW+1)'(DEPTH));
        end
    end

    // Storage needs no reset: entries are only visible through cnt_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign full_o  = full_q;
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/pwm_avm_host.sv
// Avalon-MM host issuing queued register commands to the PWM slave.
// AVM_WAITREQ_EN adds avm_waitrequest with a WAIT_TIMEOUT stall abort.
module pwm_avm_host
    import pwm_avm_pkg::*;
#(
    parameter int ADDR_W       = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
`ifdef AVM_WAITREQ_EN
    ,
    parameter int WAIT_TIMEOUT = 16
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              avm_chipselect,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic              avm_read,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata
`ifdef AVM_WAITREQ_EN
    ,
    input  logic              avm_waitrequest
`endif
);

    localparam int CW = 1 + ADDR_W + 32 + 4;
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_e            state_q, state_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic              rv_q, rv_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              stall;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_out;

`ifdef AVM_WAITREQ_EN
    localparam int TW = $clog2(WAIT_TIMEOUT) + 1;
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic          tmo;
    assign stall = avm_waitrequest;
    assign tmo   = (wcnt_q == TW'(WAIT_TIMEOUT - 1));
`else
    assign stall = 1'b0;
`endif

    pwm_avm_cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (cmd_valid),
        .data_i  ({cmd_write, cmd_addr, cmd_wdata, cmd_be}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cs_d     = cs_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        lat_d    = lat_q;
        rv_d     = rv_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
`ifdef AVM_WAITREQ_EN
        wcnt_d   = wcnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    wr_d     = fifo_out[CW-1];
                    rd_d     = !fifo_out[CW-1];
                    cs_d     = 1'b1;
                    addr_d   = fifo_out[CW-2 -: ADDR_W];
                    wdata_d  = fifo_out[35:4];
                    be_d     = fifo_out[3:0];
                    state_d  = fifo_out[CW-1] ? ST_WR : ST_RD;
`ifdef AVM_WAITREQ_EN
                    wcnt_d   = '0;
`endif
                end
            end
            ST_WR: begin
                if (!stall) begin
                    cs_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = ST_IDLE;
`ifdef AVM_WAITREQ_EN
                end else if (tmo) begin
                    cs_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d  = wcnt_q + 1'b1;
`endif
                end
            end
            ST_RD: begin
                if (!stall) begin
                    cs_d    = 1'b0;
                    rd_d    = 1'b0;
                    lat_d   = LW'(READ_LATENCY - 1);
                    state_d = ST_RDWAIT;
`ifdef AVM_WAITREQ_EN
                end else if (tmo) begin
                    cs_d    = 1'b0;
                    rd_d    = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    rv_d    = 1'b1;
                    state_d = ST_RSP;
                end else begin
                    wcnt_d  = wcnt_q + 1'b1;
`endif
                end
            end
            ST_RDWAIT: begin
                if (lat_q == '0) begin
                    rdata_d = avm_readdata;
                    err_d   = 1'b0;
                    rv_d    = 1'b1;
                    state_d = ST_RSP;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rv_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            lat_q   <= '0;
            rv_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef AVM_WAITREQ_EN
            wcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            lat_q   <= lat_d;
            rv_q    <= rv_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef AVM_WAITREQ_EN
            wcnt_q  <= wcnt_d;
`endif
        end
    end

    assign cmd_ready      = !fifo_full;
    assign busy           = !fifo_empty || (state_q != ST_IDLE);
    assign rsp_valid      = rv_q;
    assign rsp_rdata      = rdata_q;
    assign rsp_err        = err_q;
    assign avm_chipselect = cs_q;
    assign avm_write      = wr_q;
    assign avm_read       = rd_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = be_q;

endmodule

// File: tb/tb_pwm_avm_host.sv
// Randomized bench for pwm_avm_host against a register-level reference model.
module tb_pwm_avm_host;
    import pwm_avm_pkg::*;

    localparam int RL = 3;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        avm_chipselect;
    logic [1:0]  avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
`ifdef AVM_WAITREQ_EN
    logic        avm_waitrequest = 1'b0;
    wire         wreq = avm_waitrequest;
`else
    wire         wreq = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    longint cyc = 0;
    bit rr_rand = 0;
    bit abort_next = 0;

    pwm_avm_host #(
        .ADDR_W       (2),
        .FIFO_DEPTH   (4),
        .READ_LATENCY (RL)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .cmd_be          (cmd_be),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .busy            (busy),
        .avm_chipselect  (avm_chipselect),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_read        (avm_read),
        .avm_byteenable  (avm_byteenable),
        .avm_readdata    (avm_readdata)
`ifdef AVM_WAITREQ_EN
        ,
        .avm_waitrequest (avm_waitrequest)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // PWM slave stand-in: data valid only exactly RL cycles after the read strobe.
    logic [31:0] smem [4];
    logic [RL-1:0] sr_v = '0;
    logic [31:0] sr_d [RL];

    always @(posedge clk) begin
        if (avm_chipselect && !wreq && avm_write)
            smem[avm_address] <= merge(smem[avm_address], avm_writedata,
                                       avm_byteenable);
        for (int i = RL - 1; i > 0; i--) begin
            sr_v[i] <= sr_v[i-1];
            sr_d[i] <= sr_d[i-1];
        end
        sr_v[0] <= avm_chipselect && !wreq && avm_read;
        sr_d[0] <= smem[avm_address];
    end
    assign avm_readdata = sr_v[RL-1] ? sr_d[RL-1] : 32'hBAD0_BAD0;

    // Reference model: register image plus in-order expected bus ops and responses.
    logic [31:0] mmem [4];
    cmd_t        bus_q [$];
    logic [32:0] rsp_q [$];
    bit          prev_acc = 0;
    bit          prev_rv = 0;
    bit          prev_rr = 0;
    logic [31:0] prev_rd = '0;
    longint      rd_cyc = 0;

    always @(negedge clk) begin
        cmd_t c;
        logic [32:0] e;
        bit acc;
        if (!reset_n) begin
            bus_q.delete();
            rsp_q.delete();
            prev_acc = 0;
            prev_rv = 0;
            prev_rr = 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                c = '{cmd_write, cmd_addr, cmd_wdata, cmd_be};
                if (cmd_write) begin
                    mmem[cmd_addr] = merge(mmem[cmd_addr], cmd_wdata, cmd_be);
                    bus_q.push_back(c);
                end else if (abort_next) begin
                    rsp_q.push_back({1'b1, 32'h0});
                end else begin
                    rsp_q.push_back({1'b0, mmem[cmd_addr]});
                    bus_q.push_back(c);
                end
            end
            if (avm_chipselect || avm_write || avm_read)
                check("strobe_enc", {avm_chipselect, avm_write ^ avm_read},
                      2'b11);
            acc = avm_chipselect && !wreq;
            if (acc) begin
                check("no_b2b", prev_acc, 0);
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", 1, 0);
                end else begin
                    c = bus_q.pop_front();
                    check("bus_op", {avm_write, avm_read, avm_address,
                                     avm_byteenable},
                          {c.write, !c.write, c.addr, c.be});
                    if (c.write) check("bus_wdata", avm_writedata, c.wdata);
                end
                if (avm_read) rd_cyc = cyc;
            end
            prev_acc = acc;
            if (rsp_valid && !prev_rv && !rsp_err)
                check("rsp_lat", 32'(cyc - rd_cyc), RL + 1);
            if (rsp_valid && prev_rv && !prev_rr)
                check("rsp_hold", rsp_rdata, prev_rd);
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp", {rsp_err, rsp_rdata}, e);
                end
            end
            prev_rv = rsp_valid;
            prev_rr = rsp_ready;
            prev_rd = rsp_rdata;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rr_rand) rsp_ready = 1'($urandom_range(0, 1));
    end

    task automatic push(input bit w, input logic [1:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        int n = 0;
        bit ok;
        cmd_write = w;
        cmd_addr = a;
        cmd_wdata = d;
        cmd_be = be;
        cmd_valid = 1'b1;
        forever begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 300) begin
                check("push_timeout", 1, 0);
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4; i++) begin
            smem[i] = '0;
            mmem[i] = '0;
        end
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_outs", {busy, avm_chipselect, avm_write, avm_read,
                           rsp_valid, rsp_err}, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        rsp_ready = 1'b1;
        push(1, REG_CLK_DIV, 32'hFF, 4'hF);
        wait_idle();
        check("t1_norsp", rsp_valid, 0);
        push(0, REG_CLK_DIV, 32'h0, 4'hF);
        wait_idle();

        rsp_ready = 1'b0;
        push(0, REG_CLK_DIV, 32'h0, 4'hF);
        push(1, REG_DUTY, 32'hAA, 4'hF);
        push(1, REG_CTRL, 32'h1, 4'hF);
        push(1, REG_CLK_DIV, 32'h1234_5678, 4'h3);
        push(1, REG_CTRL, 32'h0, 4'h0);
        repeat (4) @(negedge clk);
        check("t3_full", cmd_ready, 0);
        check("t3_busy", busy, 1);
        check("t3_hold", rsp_valid, 1);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_idle();
        push(0, REG_DUTY, 32'h0, 4'hF);
        wait_idle();

        push(0, REG_CTRL, 32'h0, 4'hF);
        n = 0;
        @(negedge clk);
        while (!avm_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_rdseen", avm_read, 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t5_outs", {avm_chipselect, avm_read, avm_write,
                          rsp_valid, busy}, 0);
        check("t5_ready", cmd_ready, 1);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        push(0, REG_CTRL, 32'h0, 4'hF);
        wait_idle();

`ifdef AVM_WAITREQ_EN
        avm_waitrequest = 1'b1;
        abort_next = 1;
        push(0, REG_CLK_DIV, 32'h0, 4'hF);
        abort_next = 0;
        n = 0;
        @(negedge clk);
        while (!avm_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (avm_read && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_stall", n, TO);
        repeat (4) @(negedge clk);
        avm_waitrequest = 1'b0;
        wait_idle();
`endif

        rr_rand = 1;
        for (int k = 0; k < 80; k++) begin
            push(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                 $urandom, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rr_rand = 0;
        #2 rsp_ready = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);
        check("end_bus_q", bus_q.size(), 0);
        check("end_rsp_q", rsp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
